fifo_drain_ctrl: RTL
====================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter: FILL_LEVEL, 128, rdusedw threshold (1..255) that must be reached before streaming starts.
REQ-002 Parameter: UFLOW_LIMIT, 4, consecutive empty RUN cycles (1..15) that force a return to PREFILL.
REQ-003 Parameter: IDLE_WORD, 20'h00000, dout value whenever dout_valid is low.
REQ-004 Port: clk  in  1  single clock; same clock as the FIFO read side.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: enable  in  1  level; high requests streaming.
REQ-007 Port: fifo_q  in  20  FIFO read data; normal mode, valid the cycle after rdreq.
REQ-008 Port: fifo_rdempty  in  1  FIFO empty flag.
REQ-009 Port: fifo_rdusedw  in  8  FIFO read-side fill level.
REQ-010 Port: fifo_rdreq  out  1  FIFO pop request.
REQ-011 Port: dout  out  20  registered output word.
REQ-012 Port: dout_valid  out  1  dout carries FIFO data.
REQ-013 Port: underflow  out  1  one-cycle pulse per empty cycle in RUN.
REQ-014 Port: underflow_cnt  out  16  saturating underflow count.
REQ-015 Port: state  out  2  FSM state: 0 IDLE, 1 PREFILL, 2 RUN.

Function
REQ-016 FSM states SHALL be IDLE, PREFILL, RUN; all transitions on clk edge.
REQ-017 IDLE->PREFILL when enable=1; any state->IDLE when enable=0 (priority over all other transitions).
REQ-018 PREFILL->RUN when enable=1 and fifo_rdusedw >= FILL_LEVEL (unsigned 8-bit compare).
REQ-019 fifo_rdreq SHALL be combinational: (state==RUN) && enable && !fifo_rdempty; never asserted in IDLE/PREFILL.
REQ-020 A one-deep pending flag SHALL register fifo_rdreq; when set, dout<=fifo_q and dout_valid<=1 next edge; else dout<=IDLE_WORD, dout_valid<=0.
REQ-021 Latency: rdreq at cycle N -> fifo_q sampled at N+1 -> dout/dout_valid visible at N+2; one word per cycle sustained, no bubbles while FIFO non-empty.
REQ-022 A read issued in the last RUN cycle before enable falls SHALL still be delivered with dout_valid=1; no data dropped or duplicated.
REQ-023 Underflow: in RUN with enable=1 and fifo_rdempty=1, underflow=1 for that cycle (registered, visible next cycle); no rdreq issued.
REQ-024 A 4-bit empty-run counter SHALL increment on each underflow cycle, clear on any RUN cycle with rdreq=1, and clear on leaving RUN.
REQ-025 When the empty-run counter reaches UFLOW_LIMIT, RUN->PREFILL next edge.
REQ-026 underflow_cnt SHALL increment by 1 per underflow pulse, saturate at 16'hFFFF, clear only on reset.
REQ-027 Simultaneous enable fall and underflow: underflow still counted, next state IDLE.

Reset
REQ-028 reset=1 at a clk edge: state=IDLE, pending flag=0, dout=IDLE_WORD, dout_valid=0, underflow=0, underflow_cnt=0, empty-run counter=0.
REQ-029 While reset=1, fifo_rdreq SHALL be 0; reset mid-RUN discards any pending read (no dout_valid after reset).

Configuration
REQ-030 Macro FIFO_DRAIN_UFLOW_CNT_EN defined: underflow_cnt implemented per REQ-026.
REQ-031 Macro undefined: underflow_cnt tied to 16'h0000, no counter logic; all other behaviour identical, underflow pulse retained.

Verification
REQ-032 Prefill: enable=1, FIFO loaded to rdusedw=127 -> state stays 1, rdreq=0; rdusedw=128 -> state=2 next edge, first rdreq same cycle as state=2.
REQ-033 Streaming: 200 words 0x00001..0x000C8 popped back-to-back -> dout matches in order, dout_valid continuous, first valid 2 cycles after first rdreq.
REQ-034 Underflow: RUN, FIFO empties for 2 cycles then refills -> underflow pulses 2, underflow_cnt=2, state stays 2, dout=IDLE_WORD with dout_valid=0 for 2 cycles.
REQ-035 Resync: RUN, FIFO empty 4 cycles -> state=1 after 4th, underflow_cnt=4; rdusedw>=128 -> state=2.
REQ-036 Enable drop: enable falls one cycle after rdreq -> that word output with dout_valid=1, state=0, no further rdreq.
REQ-037 Reset mid-RUN with pending read -> all outputs at reset values next edge, no dout_valid; underflow_cnt=0 (and 0 always when macro undefined).

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// Drains a normal-mode FIFO into a registered stream once a fill threshold is met.
// Optional macro FIFO_DRAIN_UFLOW_CNT_EN adds the saturating underflow event counter.
module fifo_drain_ctrl #(
   parameter int unsigned FILL_LEVEL  = 128,
   parameter int unsigned UFLOW_LIMIT = 4,
   parameter logic [19:0] IDLE_WORD   = 20'h00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [19:0] fifo_q,
   input  logic        fifo_rdempty,
   input  logic [7:0]  fifo_rdusedw,
   output logic        fifo_rdreq,
   output logic [19:0] dout,
   output logic        dout_valid,
   output logic        underflow,
   output logic [15:0] underflow_cnt,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   localparam logic [7:0] FILL_LVL  = 8'(FILL_LEVEL);
   localparam logic [3:0] UFLOW_LIM = 4'(UFLOW_LIMIT);

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic [19:0] dout_q, dout_d;
   logic        dout_valid_q, dout_valid_d;
   logic        underflow_q, underflow_d;
   logic [3:0]  empty_run_q, empty_run_d;

   logic        in_run;
   logic        rdreq;
   logic        uflow_cond;
   logic        fill_ok;
   logic        limit_hit;

   always_comb begin
      in_run     = (state_q == ST_RUN);
      rdreq      = in_run && enable && !fifo_rdempty && !reset;
      uflow_cond = in_run && enable && fifo_rdempty;
      fill_ok    = (fifo_rdusedw >= FILL_LVL);
      // Resync on the underflow cycle that brings the run length to the limit.
      limit_hit  = uflow_cond &&
                   (({1'b0, empty_run_q} + 5'd1) >= {1'b0, UFLOW_LIM});
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:    state_d = ST_PREFILL;
            ST_PREFILL: if (fill_ok) state_d = ST_RUN;
            ST_RUN:     if (limit_hit) state_d = ST_PREFILL;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      empty_run_d = empty_run_q;
      if (state_d != ST_RUN || !in_run) begin
         empty_run_d = '0;
      end else if (rdreq) begin
         empty_run_d = '0;
      end else if (uflow_cond && empty_run_q != '1) begin
         empty_run_d = empty_run_q + 4'd1;
      end
   end

   always_comb begin
      pending_d    = rdreq;
      dout_valid_d = pending_q;
      dout_d       = pending_q ? fifo_q : IDLE_WORD;
      underflow_d  = uflow_cond;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pending_q    <= 1'b0;
         dout_q       <= IDLE_WORD;
         dout_valid_q <= 1'b0;
         underflow_q  <= 1'b0;
         empty_run_q  <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         underflow_q  <= underflow_d;
         empty_run_q  <= empty_run_d;
      end
   end

`ifdef FIFO_DRAIN_UFLOW_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   always_comb begin
      ucnt_d = ucnt_q;
      if (uflow_cond && ucnt_q != '1) begin
         ucnt_d = ucnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ucnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underflow_cnt = ucnt_q;
`else
   assign underflow_cnt = '0;
`endif

   assign fifo_rdreq = rdreq;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign underflow  = underflow_q;
   assign state      = state_q;

endmodule
